// File: rtl/pipe_adder_pkg.sv
// rtl/pipe_adder_pkg.sv - shared encodings for the pipelined adder/subtractor
package pipe_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_ADDC = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_SBB  = 2'b11
    } mode_e;

    // Status-register packing order: bit3=C, bit2=V, bit1=Z, bit0=N.
    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// rtl/pipe_adder_stage.sv - one chunk-wide add slice with its pipeline register
module pipe_adder_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_valid,
    input  logic             i_cin,
    input  logic [WIDTH-1:0] i_res,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_res_nxt,
    output logic             o_cout_nxt,
    output logic             o_valid,
    output logic             o_cout,
    output logic [WIDTH-1:0] o_res,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   w_sum;
    logic             r_valid;
    logic             r_cout;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    assign w_sum = {1'b0, i_a[LO +: CHUNK]} + {1'b0, i_b[LO +: CHUNK]}
                 + {{CHUNK{1'b0}}, i_cin};

    // Lower chunks come from earlier stages; only this stage's chunk is replaced.
    always_comb begin
        o_res_nxt = i_res;
        o_res_nxt[LO +: CHUNK] = w_sum[CHUNK-1:0];
    end

    assign o_cout_nxt = w_sum[CHUNK];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_cout  <= 1'b0;
            r_res   <= '0;
            r_a     <= '0;
            r_b     <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_cout  <= w_sum[CHUNK];
            r_res   <= o_res_nxt;
            r_a     <= i_a;
            r_b     <= i_b;
        end
    end

    assign o_valid = r_valid;
    assign o_cout  = r_cout;
    assign o_res   = r_res;
    assign o_a     = r_a;
    assign o_b     = r_b;

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined two's-complement adder/subtractor with valid/ready handshake
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    input  logic [1:0]       i_mode,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_y,
    output logic             o_c,
    output logic             o_v,
    output logic             o_z,
    output logic             o_n,
    output logic             o_out_valid,
    input  logic             i_out_ready
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             w_stall;
    logic             w_en;
    logic [WIDTH-1:0] w_beff;
    logic             w_cin;

    // Index k feeds stage k; index k+1 is stage k's registered output.
    logic             w_valid   [STAGES+1];
    logic             w_carry   [STAGES+1];
    logic [WIDTH-1:0] w_res     [STAGES+1];
    logic [WIDTH-1:0] w_a       [STAGES+1];
    logic [WIDTH-1:0] w_b       [STAGES+1];
    logic [WIDTH-1:0] w_res_nxt [STAGES];
    logic             w_cout_nxt[STAGES];

    logic [WIDTH-1:0] w_y_nxt;
    logic             w_a_msb;
    logic             w_b_msb;
    flags_t           w_flags_nxt;
    flags_t           r_flags;

    assign w_stall    = o_out_valid & ~i_out_ready;
    assign w_en       = ~w_stall;
    assign o_in_ready = ~w_stall;

    always_comb begin
        w_beff = i_b;
        w_cin  = 1'b0;
        unique case (mode_e'(i_mode))
            MODE_ADD:  w_cin = 1'b0;
            MODE_ADDC: w_cin = i_ci;
            MODE_SUB: begin
                w_beff = ~i_b;
                w_cin  = 1'b1;
            end
            MODE_SBB: begin
                w_beff = ~i_b;
                w_cin  = i_ci;
            end
        endcase
    end

    assign w_valid[0] = i_in_valid;
    assign w_carry[0] = w_cin;
    assign w_res[0]   = '0;
    assign w_a[0]     = i_a;
    assign w_b[0]     = w_beff;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_adder_stage #(
            .WIDTH(WIDTH),
            .CHUNK(CHUNK),
            .IDX  (k)
        ) u_stage (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_en      (w_en),
            .i_valid   (w_valid[k]),
            .i_cin     (w_carry[k]),
            .i_res     (w_res[k]),
            .i_a       (w_a[k]),
            .i_b       (w_b[k]),
            .o_res_nxt (w_res_nxt[k]),
            .o_cout_nxt(w_cout_nxt[k]),
            .o_valid   (w_valid[k+1]),
            .o_cout    (w_carry[k+1]),
            .o_res     (w_res[k+1]),
            .o_a       (w_a[k+1]),
            .o_b       (w_b[k+1])
        );
    end

    // Flags come from the last stage's combinational sum so they register alongside Y.
    assign w_y_nxt = w_res_nxt[STAGES-1];
    assign w_a_msb = w_a[STAGES-1][WIDTH-1];
    assign w_b_msb = w_b[STAGES-1][WIDTH-1];

    always_comb begin
        w_flags_nxt   = '0;
        w_flags_nxt.c = w_cout_nxt[STAGES-1];
        w_flags_nxt.v = (w_a_msb == w_b_msb) && (w_y_nxt[WIDTH-1] != w_a_msb);
        w_flags_nxt.z = (w_y_nxt == '0);
        w_flags_nxt.n = w_y_nxt[WIDTH-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= '0;
        end else if (w_en) begin
            r_flags <= w_flags_nxt;
        end
    end

    assign o_y         = w_res[STAGES];
    assign o_out_valid = w_valid[STAGES];
    assign o_c         = r_flags.c;
    assign o_v         = r_flags.v;
    assign o_z         = r_flags.z;
    assign o_n         = r_flags.n;

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake. It splits a WIDTH-bit operation into STAGES equal chunks and adds one chunk per clock, passing the carry stage to stage. It returns the sum with carry, overflow, zero and negative flags. It is the datapath's wide arithmetic unit, replacing the fixed 8-bit combinational adder wherever operands exceed 8 bits or timing closure needs registered carry.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth; chunk width CHUNK = WIDTH/STAGES; STAGES=1 is legal
- CLK  in  1  single clock; all state on rising edge
- RST_N  in  1  reset; asynchronous, active-low
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- CI  in  1  carry-in; used by ADDC and SBB only
- MODE  in  2  operation: 00 ADD, 01 ADDC, 10 SUB, 11 SBB
- IN_VALID  in  1  A/B/CI/MODE valid
- IN_READY  out  1  block accepts input this cycle
- Y  out  WIDTH  result
- C  out  1  carry out of MSB (SUB/SBB: 1 = no borrow)
- V  out  1  signed overflow
- Z  out  1  Y == 0
- N  out  1  Y[WIDTH-1]
- OUT_VALID  out  1  Y and flags valid
- OUT_READY  in  1  consumer takes result

## Operation
- Effective operand Beff = B for ADD/ADDC and ~B for SUB/SBB.
- Effective carry-in:
  - ADD: 0
  - ADDC: CI
  - SUB: 1
  - SBB: CI
- Y = A + Beff + cin mod 2^WIDTH. C is bit WIDTH of the same sum.
- V = (A[msb] == Beff[msb]) & (Y[msb] != A[msb]).
- Z and N are computed from the final Y.
- Stage k (0..STAGES-1) adds chunk k of A and Beff plus the carry registered from stage k-1 (stage 0 uses the effective carry-in).
- Each stage registers:
  - the accumulated low result bits
  - the chunk carry-out
  - the unconsumed upper operand chunks
  - A[msb] and Beff[msb]
  - a valid bit
- Flags are computed in the last stage and registered together with Y. All outputs come from registers.
- stall = OUT_VALID & ~OUT_READY; IN_READY = ~stall.
- A transfer occurs on an edge where IN_VALID & IN_READY.
- When not stalled, all stages advance together. Bubbles (invalid slots) move through and are not collapsed.
- When stalled, every stage register holds its value. Y, flags and OUT_VALID stay stable until OUT_READY.
- Results leave strictly in acceptance order. No result is lost or duplicated.

## Timing
- Reset (RST_N low, asynchronous):
  - all valid bits 0
  - Y=0, C=V=Z=N=0, OUT_VALID=0
  - IN_READY=1 once reset is released
  - in-flight operations are discarded
- Latency: input accepted at edge t produces OUT_VALID=1 with its result after edge t+STAGES-1. STAGES=1 gives the result after the accepting edge.
- Throughput: one operation per clock while OUT_READY=1.
- IN_READY depends combinationally on OUT_VALID (registered) and OUT_READY. There is no combinational path from IN_VALID to any output.
- Simultaneous events:
  - With OUT_VALID=1 and OUT_READY=1 in the same cycle as an input transfer, the output drains and the input enters together.
  - OUT_READY=1 while OUT_VALID=0 has no effect.
- IN_VALID while IN_READY=0: the input is not taken and must be held by the producer.
- Carry across chunk boundaries, e.g. 0xFFFF + 1, must propagate correctly through all stages.

## Structure
- Shared package holds:
  - the MODE encodings (ADD, ADDC, SUB, SBB)
  - the flag bit order {C,V,Z,N} for status-register packing
- One sub-module, adder_stage: CHUNK-bit adder with carry in/out plus its pipeline register and hold enable, instantiated STAGES times by generate.
- The top level owns the handshake, operand inversion and flag logic.

## Test plan
- Reset: drive 3 ops, assert RST_N low mid-flight -> OUT_VALID=0, Y=0 immediately. After release, IN_READY=1 and no stale results appear.
- ADD 0x7FFF + 0x0001 (WIDTH=16, STAGES=4) -> after 4 edges Y=0x8000, C=0, V=1, N=1, Z=0.
- SUB 0x0000 - 0x0001 -> Y=0xFFFF, C=0 (borrow), V=0, N=1. SUB 0x8000 - 0x0001 -> Y=0x7FFF, C=1, V=1.
- ADDC 0xFFFF + 0x0000 with CI=1 -> Y=0x0000, C=1, Z=1, V=0, exercising carry through all 4 chunks.
- Back-to-back 6 random ops with OUT_READY low for 3 cycles after the first result -> IN_READY=0 during the stall, Y stable, all 6 results correct and in order.
- WIDTH=8, STAGES=1: 0x80 + 0x80 ADD -> Y=0x00, C=1, V=1, Z=1, with latency of one edge.
